// File: rtl/ni_eject.sv
// rtl/ni_eject.sv - router local-port ejection interface: ingress FIFO, destination check, word stream out
module ni_eject #(
  parameter int LINK_WIDTH = 8,
  parameter int MESH_DIM   = 4,
  parameter int ROUTER_ID  = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int SKID       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LINK_WIDTH-1:0] flit_in,
  input  logic                  flit_in_wr_en,
  output logic                  on_off,
  output logic [LINK_WIDTH-3:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [15:0]           pkt_count,
  output logic                  err_dest,
  output logic                  err_proto,
  output logic                  err_ovf
);

  localparam int ADDR_W = $clog2(MESH_DIM * MESH_DIM);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PASS = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_TAIL = 2'b01;
  localparam logic [1:0] T_HEAD = 2'b10;
  localparam logic [1:0] T_HT   = 2'b11;

  logic [LINK_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [1:0]            r_state;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_ovf;
  logic [CNT_W-1:0]      w_count_next;
  logic [LINK_WIDTH-1:0] w_flit;
  logic [1:0]            w_type;
  logic                  w_dest_ok;

  logic [1:0]            w_next_state;
  logic                  w_load;
  logic                  w_sop;
  logic                  w_eop;
  logic                  w_pkt_inc;
  logic                  w_err_dest;
  logic                  w_err_proto;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
  // DROP drains regardless of the core so a stalled consumer cannot wedge the link
  assign w_pop     = !w_empty && ((r_state == DROP) || !out_valid || out_ready);
  assign w_push    = flit_in_wr_en && (!w_full || w_pop);
  assign w_ovf     = flit_in_wr_en && w_full && !w_pop;
  assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  assign w_flit    = r_mem[r_rd_ptr];
  assign w_type    = w_flit[LINK_WIDTH-1:LINK_WIDTH-2];
  assign w_dest_ok = (w_flit[ADDR_W-1:0] == ADDR_W'(ROUTER_ID));

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_sop        = 1'b0;
    w_eop        = 1'b0;
    w_pkt_inc    = 1'b0;
    w_err_dest   = 1'b0;
    w_err_proto  = 1'b0;
    if (w_pop) begin
      if (r_state == DROP) begin
        if (w_type[0]) w_next_state = IDLE;
      end else if (r_state == PASS && w_type == T_BODY) begin
        w_load = 1'b1;
      end else if (r_state == PASS && w_type == T_TAIL) begin
        w_load       = 1'b1;
        w_eop        = 1'b1;
        w_pkt_inc    = 1'b1;
        w_next_state = IDLE;
      end else begin
        // IDLE, or a head arriving inside an open packet: abandon it and start over
        if (r_state == PASS) w_err_proto = 1'b1;
        case (w_type)
          T_HEAD: begin
            if (w_dest_ok) begin
              w_load       = 1'b1;
              w_sop        = 1'b1;
              w_next_state = PASS;
            end else begin
              w_err_dest   = 1'b1;
              w_next_state = DROP;
            end
          end
          T_HT: begin
            w_next_state = IDLE;
            if (w_dest_ok) begin
              w_load    = 1'b1;
              w_sop     = 1'b1;
              w_eop     = 1'b1;
              w_pkt_inc = 1'b1;
            end else begin
              w_err_dest = 1'b1;
            end
          end
          default: begin
            w_err_proto  = 1'b1;
            w_next_state = IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= flit_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_state   <= IDLE;
      on_off    <= 1'b1;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      pkt_count <= '0;
      err_dest  <= 1'b0;
      err_proto <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count   <= w_count_next;
      r_state   <= w_next_state;
      on_off    <= ((FIFO_DEPTH - int'(w_count_next)) > SKID);
      err_dest  <= w_err_dest;
      err_proto <= w_err_proto;
      err_ovf   <= w_ovf;
      if (w_pkt_inc) pkt_count <= pkt_count + 16'd1;
      if (w_load) begin
        out_data  <= w_flit[LINK_WIDTH-3:0];
        out_sop   <= w_sop;
        out_eop   <= w_eop;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ni_eject.sv
// tb/tb_ni_eject.sv - scoreboard bench for ni_eject with directed packets
module tb_ni_eject;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  flit_in = 8'h00;
  logic        flit_in_wr_en = 1'b0;
  logic        on_off;
  logic [5:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_sop;
  logic        out_eop;
  logic [15:0] pkt_count;
  logic        err_dest;
  logic        err_proto;
  logic        err_ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_dest = 0;
  int cnt_proto = 0;
  int cnt_ovf  = 0;
  logic [7:0] exp_q[$];

  ni_eject #(.LINK_WIDTH(8), .MESH_DIM(4), .ROUTER_ID(0), .FIFO_DEPTH(4), .SKID(2)) dut (
    .clk(clk), .rst(rst), .flit_in(flit_in), .flit_in_wr_en(flit_in_wr_en),
    .on_off(on_off), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sop(out_sop), .out_eop(out_eop), .pkt_count(pkt_count),
    .err_dest(err_dest), .err_proto(err_proto), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor: pop expected {sop,eop,data} on every accepted word, tally error pulses
  always @(negedge clk) begin
    if (rst) begin
      if (err_dest)  cnt_dest++;
      if (err_proto) cnt_proto++;
      if (err_ovf)   cnt_ovf++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL word_unexpected: got sop=%0b eop=%0b data=0x%0h expected none",
                   out_sop, out_eop, out_data);
        end else begin
          chk("word", {24'd0, out_sop, out_eop, out_data}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic send(input logic [7:0] f);
    flit_in = f;
    flit_in_wr_en = 1'b1;
    @(posedge clk); #1;
    flit_in_wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain(input string name);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || out_valid) && c < 60) begin
      @(posedge clk); #1;
      c++;
    end
    n_checks++;
    if (exp_q.size() != 0 || out_valid) begin
      n_fail++;
      $display("FAIL %s_drain: %0d words outstanding after %0d cycles, expected 0", name, exp_q.size(), c);
      exp_q.delete();
    end
    idle(3);
  endtask

  function automatic logic [7:0] w(input logic sop, input logic eop, input logic [5:0] d);
    return {sop, eop, d};
  endfunction

  logic [7:0] t4_flits [6];

  initial begin
    #12;
    chk("rst_on_off", 32'(on_off), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sop_eop", {30'd0, out_sop, out_eop}, 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_pkt_count", 32'(pkt_count), 32'd0);
    chk("rst_errs", {29'd0, err_dest, err_proto, err_ovf}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle(2);
    chk("post_rst_on_off", 32'(on_off), 32'd1);

    // four-flit packet, latency and throughput
    exp_q.push_back(w(1, 0, 6'h00));
    exp_q.push_back(w(0, 0, 6'h15));
    exp_q.push_back(w(0, 0, 6'h2A));
    exp_q.push_back(w(0, 1, 6'h3F));
    send(8'h80);
    chk("lat_n1_valid", 32'(out_valid), 32'd0);
    send(8'h15);
    chk("lat_n2_valid", 32'(out_valid), 32'd1);
    send(8'h2A);
    send(8'h7F);
    drain("pkt4");
    chk("pkt4_count", 32'(pkt_count), 32'd1);

    // single-flit packet
    exp_q.push_back(w(1, 1, 6'h00));
    send(8'hC0);
    drain("ht");
    chk("ht_count", 32'(pkt_count), 32'd2);

    // wrong destination, then single-flit proves FSM back in IDLE
    send(8'h85);
    send(8'h00);
    send(8'h40);
    idle(4);
    chk("dest_err_count", 32'(cnt_dest), 32'd1);
    chk("dest_no_output", 32'(out_valid), 32'd0);
    exp_q.push_back(w(1, 1, 6'h00));
    send(8'hC0);
    drain("after_drop");
    chk("after_drop_count", 32'(pkt_count), 32'd3);
    chk("drop_no_proto", 32'(cnt_proto), 32'd0);

    // backpressure with on_off obeyed through a 2-cycle reaction
    begin
      int sent;
      logic d1, d2, cur, saw_off;
      t4_flits = '{8'h80, 8'h01, 8'h02, 8'h03, 8'h04, 8'h45};
      exp_q.push_back(w(1, 0, 6'h00));
      exp_q.push_back(w(0, 0, 6'h01));
      exp_q.push_back(w(0, 0, 6'h02));
      exp_q.push_back(w(0, 0, 6'h03));
      exp_q.push_back(w(0, 0, 6'h04));
      exp_q.push_back(w(0, 1, 6'h05));
      out_ready = 1'b0;
      sent = 0; d1 = 1'b1; d2 = 1'b1; saw_off = 1'b0;
      for (int c = 0; c < 200 && sent < 6; c++) begin
        if (c == 12) out_ready = 1'b1;
        cur = on_off;
        if (!cur) saw_off = 1'b1;
        if (d2) begin
          flit_in = t4_flits[sent];
          flit_in_wr_en = 1'b1;
          sent++;
        end else begin
          flit_in_wr_en = 1'b0;
        end
        d2 = d1;
        d1 = cur;
        @(posedge clk); #1;
      end
      flit_in_wr_en = 1'b0;
      out_ready = 1'b1;
      chk("bp_all_sent", 32'(sent), 32'd6);
      chk("bp_saw_off", 32'(saw_off), 32'd1);
      drain("bp");
      chk("bp_no_ovf", 32'(cnt_ovf), 32'd0);
      chk("bp_count", 32'(pkt_count), 32'd4);
    end

    // protocol errors
    send(8'h01);
    idle(3);
    chk("proto_body_idle", 32'(cnt_proto), 32'd1);
    chk("proto_no_output", 32'(out_valid), 32'd0);
    exp_q.push_back(w(1, 0, 6'h00));
    exp_q.push_back(w(0, 0, 6'h11));
    exp_q.push_back(w(1, 0, 6'h00));
    exp_q.push_back(w(0, 0, 6'h22));
    exp_q.push_back(w(0, 1, 6'h3F));
    send(8'h80);
    send(8'h11);
    send(8'h80);
    send(8'h22);
    send(8'h7F);
    drain("proto_pass");
    chk("proto_head_in_pass", 32'(cnt_proto), 32'd2);
    chk("proto_count", 32'(pkt_count), 32'd5);

    // overflow: output register occupied, then five writes
    out_ready = 1'b0;
    exp_q.push_back(w(1, 1, 6'h00));
    exp_q.push_back(w(1, 0, 6'h00));
    exp_q.push_back(w(0, 0, 6'h01));
    exp_q.push_back(w(0, 0, 6'h02));
    exp_q.push_back(w(0, 0, 6'h03));
    exp_q.push_back(w(0, 1, 6'h3F));
    send(8'hC0);
    idle(1);
    chk("ovf_hold_valid", 32'(out_valid), 32'd1);
    send(8'h80);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    chk("ovf_before_5th", 32'(err_ovf), 32'd0);
    chk("ovf_on_off_low", 32'(on_off), 32'd0);
    send(8'h04);
    chk("ovf_pulse", 32'(err_ovf), 32'd1);
    idle(1);
    chk("ovf_pulse_end", 32'(err_ovf), 32'd0);
    out_ready = 1'b1;
    send(8'h7F);
    drain("ovf");
    chk("ovf_count", 32'(cnt_ovf), 32'd1);
    chk("final_pkt_count", 32'(pkt_count), 32'd7);
    chk("final_dest", 32'(cnt_dest), 32'd1);
    chk("final_proto", 32'(cnt_proto), 32'd2);
    chk("final_on_off", 32'(on_off), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
